// File: rtl/mpu_commit_track.sv
// ---------------------------------------------------------------------------
// mpu_commit_track
//
// In-order commit tracker for the MPU. Each thread the dispatcher sends to a
// subset of TPUs gets an issue number (the tracker slot). The TPUs report back
// with per-TPU commit pulses carrying that number. Once every targeted TPU has
// committed, the thread retires, always in issue order.
//
// Optional feature: define MPU_COMMIT_TIMEOUT_EN to add a head-age watchdog
// and the sticky O_Timeout output (limit set by TIMEOUT_CYCLES).
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   I_Req_Issue  dispatcher requests a slot
//   I_ThreadID   thread ID stored with the slot
//   I_En_TPU     mask of TPUs the thread is sent to
//   O_Grant      request accepted this cycle (combinational)
//   O_Issue_No   issue number handed out when O_Grant is high (combinational)
//   I_Commit     per-TPU commit pulse
//   I_Commit_No  per-TPU issue number, TPU t in slice [t*WIDTH_ISSUE +: WIDTH_ISSUE]
//   O_Retire     one-cycle registered retire pulse
//   O_Retire_ID  thread ID of the last retired entry
//   O_Retire_No  issue number of the last retired entry
//   O_Full       every slot occupied
//   O_Empty      no slot occupied
//   O_Count      number of occupied slots
//   O_Timeout    sticky watchdog flag (only with MPU_COMMIT_TIMEOUT_EN)
//   O_Err        sticky protocol-error flag
// ---------------------------------------------------------------------------
module mpu_commit_track #(
  parameter int NUM_ENTRY      = 8,
  parameter int NUM_TPUS       = 4,
  parameter int WIDTH_THREADID = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int WIDTH_ISSUE   = $clog2(NUM_ENTRY)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            I_Req_Issue,
  input  logic [WIDTH_THREADID-1:0]       I_ThreadID,
  input  logic [NUM_TPUS-1:0]             I_En_TPU,
  output logic                            O_Grant,
  output logic [WIDTH_ISSUE-1:0]          O_Issue_No,
  input  logic [NUM_TPUS-1:0]             I_Commit,
  input  logic [NUM_TPUS*WIDTH_ISSUE-1:0] I_Commit_No,
  output logic                            O_Retire,
  output logic [WIDTH_THREADID-1:0]       O_Retire_ID,
  output logic [WIDTH_ISSUE-1:0]          O_Retire_No,
  output logic                            O_Full,
  output logic                            O_Empty,
  output logic [WIDTH_ISSUE:0]            O_Count,
`ifdef MPU_COMMIT_TIMEOUT_EN
  output logic                            O_Timeout,
`endif
  output logic                            O_Err
);

  localparam int WIDTH_TPU = (NUM_TPUS > 1) ? $clog2(NUM_TPUS) : 1;
  localparam logic [WIDTH_ISSUE:0] FULL_COUNT = (WIDTH_ISSUE+1)'(NUM_ENTRY);

  // Tracker storage
  logic [NUM_ENTRY-1:0]      r_Valid;
  logic [WIDTH_THREADID-1:0] r_ThreadID [NUM_ENTRY];
  logic [NUM_TPUS-1:0]       r_Pending  [NUM_ENTRY];
  logic [WIDTH_ISSUE-1:0]    r_Wp;
  logic [WIDTH_ISSUE-1:0]    r_Rp;
  logic [WIDTH_ISSUE:0]      r_Count;

  // Registered outputs
  logic                      r_Retire;
  logic [WIDTH_THREADID-1:0] r_RetireID;
  logic [WIDTH_ISSUE-1:0]    r_RetireNo;
  logic                      r_Err;

  // Per-cycle decisions
  logic                      w_Grant;
  logic                      w_DoRetire;
  logic                      w_CommitErr;
  logic [WIDTH_ISSUE-1:0]    w_CommitNo  [NUM_TPUS];
  logic [NUM_TPUS-1:0]       w_ClearMask [NUM_ENTRY];

  // Unpack the flat commit-number bus into one issue number per TPU.
  for (genvar g = 0; g < NUM_TPUS; g++) begin : g_commitNo
    assign w_CommitNo[g] = I_Commit_No[g*WIDTH_ISSUE +: WIDTH_ISSUE];
  end

  assign O_Full     = (r_Count == FULL_COUNT);
  assign O_Empty    = (r_Count == '0);
  assign O_Count    = r_Count;
  // No bypass when full: a retire in the same cycle does not free the slot
  // early, so the grant only looks at the registered occupancy.
  assign w_Grant    = I_Req_Issue & ~O_Full;
  assign O_Grant    = w_Grant;
  assign O_Issue_No = r_Wp;
  // The head retires once it is valid and no targeted TPU is still pending.
  assign w_DoRetire = r_Valid[r_Rp] && (r_Pending[r_Rp] == '0);

  assign O_Retire    = r_Retire;
  assign O_Retire_ID = r_RetireID;
  assign O_Retire_No = r_RetireNo;
  assign O_Err       = r_Err;

  // Decode every commit pulse into a pending-bit clear. A commit to a slot
  // that is not valid, or whose bit for that TPU is already clear, changes
  // nothing and raises the error flag instead. A slot being allocated this
  // cycle is still invalid, so commits to it are errors too.
  always_comb begin
    w_CommitErr = 1'b0;
    for (int e = 0; e < NUM_ENTRY; e++) begin
      w_ClearMask[WIDTH_ISSUE'(e)] = '0;
    end
    for (int t = 0; t < NUM_TPUS; t++) begin
      if (I_Commit[WIDTH_TPU'(t)]) begin
        if (r_Valid[w_CommitNo[t]] && r_Pending[w_CommitNo[t]][WIDTH_TPU'(t)]) begin
          w_ClearMask[w_CommitNo[t]][WIDTH_TPU'(t)] = 1'b1;
        end else begin
          w_CommitErr = 1'b1;
        end
      end
    end
  end

  // Slot state, pointers and occupancy. Allocation and retire always touch
  // different slots (full blocks allocation when wp == rp), and commits only
  // clear bits of valid slots, so the updates never collide.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_Valid <= '0;
      for (int e = 0; e < NUM_ENTRY; e++) begin
        r_Pending[WIDTH_ISSUE'(e)] <= '0;
      end
      r_Wp    <= '0;
      r_Rp    <= '0;
      r_Count <= '0;
    end else begin
      for (int e = 0; e < NUM_ENTRY; e++) begin
        r_Pending[WIDTH_ISSUE'(e)] <= r_Pending[WIDTH_ISSUE'(e)] & ~w_ClearMask[WIDTH_ISSUE'(e)];
      end
      if (w_Grant) begin
        r_Valid[r_Wp]   <= 1'b1;
        r_Pending[r_Wp] <= I_En_TPU;
        r_Wp            <= r_Wp + 1'b1;
      end
      if (w_DoRetire) begin
        r_Valid[r_Rp] <= 1'b0;
        r_Rp          <= r_Rp + 1'b1;
      end
      case ({w_Grant, w_DoRetire})
        2'b10:   r_Count <= r_Count + 1'b1;
        2'b01:   r_Count <= r_Count - 1'b1;
        default: r_Count <= r_Count;
      endcase
    end
  end

  // Thread IDs are only ever read from valid slots, so they need no reset.
  always_ff @(posedge clock) begin
    if (w_Grant) begin
      r_ThreadID[r_Wp] <= I_ThreadID;
    end
  end

  // Retire pulse and the retired thread's identity; the identity holds its
  // last value between retires. The error flag is sticky until reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_Retire   <= 1'b0;
      r_RetireID <= '0;
      r_RetireNo <= '0;
      r_Err      <= 1'b0;
    end else begin
      r_Retire <= w_DoRetire;
      if (w_DoRetire) begin
        r_RetireID <= r_ThreadID[r_Rp];
        r_RetireNo <= r_Rp;
      end
      if (w_CommitErr) begin
        r_Err <= 1'b1;
      end
    end
  end

`ifdef MPU_COMMIT_TIMEOUT_EN
  logic [31:0] r_HeadAge;
  logic        r_Timeout;

  // Head-age watchdog: counts cycles the head slot spends valid but
  // incomplete, restarts on every retire and while the tracker is empty,
  // and saturates rather than wrapping. Crossing the limit latches the
  // timeout flag until reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_HeadAge <= '0;
      r_Timeout <= 1'b0;
    end else begin
      if (w_DoRetire || O_Empty) begin
        r_HeadAge <= '0;
      end else if (r_Valid[r_Rp] && (|r_Pending[r_Rp]) && (r_HeadAge != '1)) begin
        r_HeadAge <= r_HeadAge + 32'd1;
      end
      if (r_HeadAge >= 32'(TIMEOUT_CYCLES)) begin
        r_Timeout <= 1'b1;
      end
    end
  end

  assign O_Timeout = r_Timeout;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

endmodule
